// File: rtl/mac_run_monitor.sv
// mac_run_monitor: snoops the AXIS handshake feeding the byte-sum MAC and
// measures one run of programmable length (accepted beats and elapsed cycles).
// After the run it waits SUM_LAT cycles for the MAC pipeline to drain, then
// latches partial_sum as the run result.
//
// Optional build macro MAC_RUN_MONITOR_STALL_CNT_EN adds stall_cnt: the number
// of RUN cycles with s_axis_tvalid low (DDR-side stalls).
//
// The block never drives the handshake. A beat is any cycle with
// s_axis_tvalid & s_axis_tready; there is no other valid/ready protocol here.
module mac_run_monitor #(
    parameter int SUM_LAT = 2,
    parameter int CW      = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic [CW-1:0] timeout,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tready,
    input  logic [31:0]   partial_sum,
    output logic          busy,
    output logic          done,
    output logic          timed_out,
    output logic [31:0]   result_sum,
    output logic [CW-1:0] beat_cnt,
    output logic [CW-1:0] cycle_cnt,
`ifdef MAC_RUN_MONITOR_STALL_CNT_EN
    output logic [CW-1:0] stall_cnt,
`endif
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DW = (SUM_LAT > 1) ? $clog2(SUM_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(SUM_LAT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_len;
    logic [CW-1:0]   r_timeout;
    logic [CW-1:0]   r_beat_cnt;
    logic [CW-1:0]   r_cycle_cnt;
    logic [31:0]     r_result_sum;
    logic            r_done;
    logic            r_timed_out;
    logic [DW-1:0]   r_drain_cnt;

    logic            w_beat;
    logic [CW-1:0]   w_beat_inc;
    logic [CW-1:0]   w_cycle_inc;
    logic            w_last_beat;
    logic            w_tmo_hit;
    logic            w_drain_last;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign w_beat      = s_axis_tvalid & s_axis_tready;
    assign w_beat_inc  = (r_beat_cnt  == '1) ? r_beat_cnt  : r_beat_cnt  + CW'(1);
    assign w_cycle_inc = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + CW'(1);

    // The last beat takes priority over a timeout landing in the same cycle.
    assign w_last_beat  = (r_state == S_RUN) && w_beat && (w_beat_inc == r_len);
    assign w_tmo_hit    = (r_state == S_RUN) && (r_timeout != '0) &&
                          (w_cycle_inc >= r_timeout) && !w_last_beat;
    assign w_drain_last = (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start restarts the run from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = (len == '0) ? S_DRAIN : S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_last_beat || w_tmo_hit) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_drain_last) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Run counters, drain timer and result latch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_len        <= '0;
            r_timeout    <= '0;
            r_beat_cnt   <= '0;
            r_cycle_cnt  <= '0;
            r_result_sum <= '0;
            r_done       <= 1'b0;
            r_timed_out  <= 1'b0;
            r_drain_cnt  <= '0;
        end else if (start) begin
            // A beat in the start cycle is dropped: the MAC clears on this pulse.
            r_len        <= len;
            r_timeout    <= timeout;
            r_beat_cnt   <= '0;
            r_cycle_cnt  <= '0;
            r_result_sum <= '0;
            r_done       <= 1'b0;
            r_timed_out  <= 1'b0;
            r_drain_cnt  <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_cycle_cnt <= w_cycle_inc;
                    r_drain_cnt <= '0;
                    if (w_beat)    r_beat_cnt  <= w_beat_inc;
                    if (w_tmo_hit) r_timed_out <= 1'b1;
                end
                S_DRAIN: begin
                    if (w_drain_last) begin
                        r_result_sum <= partial_sum;
                        r_done       <= 1'b1;
                        r_drain_cnt  <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MAC_RUN_MONITOR_STALL_CNT_EN
    logic [CW-1:0] r_stall_cnt;

    // Count RUN cycles where the upstream (DDR) side has nothing to offer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (start) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && !s_axis_tvalid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = r_done;
    assign timed_out  = r_timed_out;
    assign result_sum = r_result_sum;
    assign beat_cnt   = r_beat_cnt;
    assign cycle_cnt  = r_cycle_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mac_run_monitor.sv
// Bench for mac_run_monitor: directed runs against a small MAC model that adds
// 3 per accepted beat with a SUM_LAT-deep pipeline. Expected run results are
// queued when a run is launched and compared when done rises.
module tb_mac_run_monitor;

  localparam int SUM_LAT = 2;
  localparam int CW      = 32;
  localparam int EW      = 32 + CW + CW + 1;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [CW-1:0] len;
  logic [CW-1:0] timeout;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [31:0]   partial_sum;
  logic          busy;
  logic          done;
  logic          timed_out;
  logic [31:0]   result_sum;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] cycle_cnt;
  logic [1:0]    dbg_state;
`ifdef MAC_RUN_MONITOR_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_q[$];
`endif

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  mac_run_monitor #(.SUM_LAT(SUM_LAT), .CW(CW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .len           (len),
    .timeout       (timeout),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .partial_sum   (partial_sum),
    .busy          (busy),
    .done          (done),
    .timed_out     (timed_out),
    .result_sum    (result_sum),
    .beat_cnt      (beat_cnt),
    .cycle_cnt     (cycle_cnt),
`ifdef MAC_RUN_MONITOR_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: accumulator clears on start, +3 per beat, SUM_LAT register stages.
  logic [31:0] mac_acc;
  logic [31:0] mac_pipe [SUM_LAT-1];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mac_acc <= '0;
      for (int i = 0; i < SUM_LAT - 1; i++) mac_pipe[i] <= '0;
    end else begin
      if (start) mac_acc <= '0;
      else if (s_axis_tvalid && s_axis_tready) mac_acc <= mac_acc + 32'd3;
      mac_pipe[0] <= mac_acc;
      for (int i = 1; i < SUM_LAT - 1; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
  end
  assign partial_sum = mac_pipe[SUM_LAT-2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_start(input logic [CW-1:0] l, input logic [CW-1:0] t, input logic beat);
    start = 1'b1; len = l; timeout = t;
    s_axis_tvalid = beat; s_axis_tready = beat;
    tick();
    start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tready = 1'b0;
  endtask

  task automatic drive_beats(input int n);
    s_axis_tvalid = 1'b1; s_axis_tready = 1'b1;
    repeat (n) tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic push_exp(input int beats, input int cycles, input logic tmo, input int stalls);
    exp_q.push_back({32'(3 * beats), CW'(beats), CW'(cycles), tmo});
`ifdef MAC_RUN_MONITOR_STALL_CNT_EN
    stall_q.push_back(CW'(stalls));
`else
    if (stalls < 0) $display("note: negative stall expectation ignored");
`endif
  endtask

  // Wait for done (bounded), report ticks taken, then score the run.
  task automatic finish_run(input string tag, input int exp_ticks);
    int n;
    logic [EW-1:0] e;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    if (exp_ticks >= 0) check({tag, "_latency"}, n, exp_ticks);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result_sum"}, result_sum, e[EW-1 -: 32]);
      check({tag, "_beat_cnt"},   beat_cnt,   e[2*CW : CW+1]);
      check({tag, "_cycle_cnt"},  cycle_cnt,  e[CW:1]);
      check({tag, "_timed_out"},  timed_out,  e[0]);
`ifdef MAC_RUN_MONITOR_STALL_CNT_EN
      check({tag, "_stall_cnt"},  stall_cnt,  stall_q.pop_front());
`endif
    end
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int extra;
    rstn = 1'b0; start = 1'b0; len = '0; timeout = '0;
    s_axis_tvalid = 1'b0; s_axis_tready = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_result", result_sum, 0);
    check("rst_beats", beat_cnt, 0);
    check("rst_cycles", cycle_cnt, 0);
    check("rst_state", dbg_state, 0);
    rstn = 1'b1;
    tick();

    // nominal: 4 back-to-back beats; done SUM_LAT ticks after the last-beat edge,
    // i.e. SUM_LAT+1 cycles counting the beat cycle itself
    push_exp(4, 4, 1'b0, 0);
    do_start(4, 0, 1'b0);
    check("nom_busy", busy, 1);
    check("nom_state_run", dbg_state, 1);
    drive_beats(4);
    check("nom_state_drain", dbg_state, 2);
    finish_run("nom", SUM_LAT);

    // beats after done change nothing
    extra = $urandom_range(2, 5);
    drive_beats(extra);
    idle(1);
    check("post_done_beats", beat_cnt, 4);
    check("post_done_cycles", cycle_cnt, 4);
    check("post_done_sum", result_sum, 12);
    check("post_done_done", done, 1);

    // gapped beats: beat, 2 idle, beat, 2 idle, beat
    push_exp(3, 7, 1'b0, 4);
    do_start(3, 0, 1'b0);
    drive_beats(1); idle(2);
    drive_beats(1); idle(2);
    drive_beats(1);
    finish_run("gap", SUM_LAT);

    // timeout: 2 of 10 beats, timeout at 5 cycles
    push_exp(2, 5, 1'b1, 3);
    do_start(10, 5, 1'b0);
    drive_beats(2);
    finish_run("tmo", -1);

    // coincident last beat and timeout: beat wins
    push_exp(5, 5, 1'b0, 0);
    do_start(5, 5, 1'b0);
    drive_beats(5);
    finish_run("coinc", SUM_LAT);

    // zero length: done SUM_LAT+1 cycles after start (start cycle included)
    push_exp(0, 0, 1'b0, 0);
    do_start(0, 0, 1'b0);
    check("zero_state_drain", dbg_state, 2);
    finish_run("zero", SUM_LAT);

    // restart during RUN; beat in the restart cycle is not counted
    do_start(8, 0, 1'b0);
    drive_beats(2);
    push_exp(8, 8, 1'b0, 0);
    do_start(8, 0, 1'b1);
    check("rst_run_beats", beat_cnt, 0);
    check("rst_run_cycles", cycle_cnt, 0);
    check("rst_run_done", done, 0);
    drive_beats(7);
    check("rst_run_no_done", done, 0);
    drive_beats(1);
    finish_run("restart", SUM_LAT);

    // reset asserted mid-DRAIN clears everything next cycle
    do_start(2, 0, 1'b0);
    drive_beats(2);
    check("mid_drain_state", dbg_state, 2);
    rstn = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result_sum, 0);
    check("mid_rst_beats", beat_cnt, 0);
    check("mid_rst_cycles", cycle_cnt, 0);
    check("mid_rst_state", dbg_state, 0);
`ifdef MAC_RUN_MONITOR_STALL_CNT_EN
    check("mid_rst_stalls", stall_cnt, 0);
`endif
    rstn = 1'b1;
    idle(SUM_LAT + 2);
    check("mid_rst_no_done", done, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
